status_register_stack: RTL
==========================

Name: status_register_stack

Overview:
Parametrised NZCV status register for the execute stage. Adds a per-flag write mask, a LIFO save/restore stack for exception and context entry/return, and combinational B.cond condition evaluation. It replaces the single-level flag register: the ALU feeds flags in, and branch logic consumes cond_true.

Parameters:
SREG_W, 32, width of the architectural status word; must be >= FLAG_LSB+4
FLAG_LSB, 28, bit position of V; C, Z and N occupy FLAG_LSB+1, +2 and +3
STACK_DEPTH, 4, number of saved status words; must be >= 1
CNT_W, $clog2(STACK_DEPTH+1), width of the depth counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
negative_in  input  1  N from ALU
zero_in  input  1  Z from ALU
carry_in  input  1  C from ALU
overflow_in  input  1  V from ALU
update_sreg  input  1  write enable for the flags
flag_mask  input  4  per-flag enable {N,Z,C,V}; a flag updates only if update_sreg and its mask bit are both 1
push  input  1  save the current sreg onto the stack
pop  input  1  restore sreg from the top of the stack
cond  input  4  LEGv8 condition code
cond_true  output  1  condition result on the current sreg
sreg  output  SREG_W  registered status word; non-flag bits are always 0
negative_out  output  1  sreg[FLAG_LSB+3]
zero_out  output  1  sreg[FLAG_LSB+2]
carry_out  output  1  sreg[FLAG_LSB+1]
overflow_out  output  1  sreg[FLAG_LSB]
depth  output  CNT_W  number of valid stack entries
stack_full  output  1  depth == STACK_DEPTH
stack_empty  output  1  depth == 0
stack_err  output  1  sticky error flag

Behaviour:
- Reset (reset low, asynchronous): sreg=0, all stack entries=0, depth=0, stack_err=0. Outputs are valid immediately and stay there until the first rising edge after release.
- All state updates on the rising clk edge. Flag updates appear on sreg one cycle after update_sreg; there is no bypass.
- The 4-bit flag nibble (N,Z,C,V) is the only storage. sreg bits outside [FLAG_LSB+3:FLAG_LSB] read 0.
- Masked update: each flag with update_sreg and its flag_mask bit set takes the corresponding *_in value. Every other flag holds.
- Push only (not full): stack[depth] <= flag nibble as it was before this edge; depth += 1. A same-cycle update_sreg still applies to sreg. This lets exception entry save the old flags and write new ones in one cycle.
- Push when full: stack and depth unchanged, stack_err <= 1, and update_sreg still applies.
- Pop only (not empty): sreg flags <= stack[depth-1]; depth -= 1. A same-cycle update_sreg is ignored; pop has priority.
- Pop when empty: stack_err <= 1; sreg takes update_sreg normally.
- Push and pop in the same cycle: stack, depth and sreg unchanged, stack_err <= 1, and update_sreg is ignored.
- stack_err is sticky and clears only on reset.
- Popped entries are not cleared; a later push overwrites them.
- cond_true is combinational from registered flags only, with no dependence on *_in. Encoding:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 HS: C
  - 3 LO: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !(C&!Z)
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: !(!Z&(N==V))
  - E AL: 1
  - F NV: 1
- Reset asserted mid-operation abandons any pending push/pop and returns to the reset state immediately.

Test Plan:
- Reset, then update_sreg=1, mask=1111, in=N1 Z0 C1 V0 -> next cycle sreg=0xA0000000, cond=A (GE) gives 0, cond=8 (HI) gives 1.
- sreg=0xF0000000, update with mask=0100, all inputs 0 -> sreg=0xB0000000 (only Z cleared).
- sreg=0x50000000, push plus update mask=1111 with inputs 0 -> sreg=0, depth=1. Then pop plus update with inputs all 1 -> sreg=0x50000000, depth=0.
- STACK_DEPTH=4: push saved words 1,2,3,4 (nibbles), then a 5th push -> depth stays 4, stack_full=1, stack_err=1. Four pops return 4,3,2,1. A 5th pop leaves sreg unchanged (no update) and stack_empty=1.
- push and pop in the same cycle with depth=2 and update_sreg=1 -> depth=2, sreg unchanged, stack_err=1.
- Assert reset low asynchronously mid-cycle at depth=3, sreg=0xC0000000 -> sreg=0, depth=0, stack_err=0 before the next edge; sweep cond 0..F on sreg=0 -> cond_true = 0,1,0,1,0,1,0,1,0,1,1,0,1,0,1,1.

Source files
------------

// File: rtl/status_register_stack.sv
// NZCV status register with per-flag write mask, LIFO save/restore stack and B.cond evaluation.
// Flags, stack and depth update one cycle after the request; cond_true is combinational from the registered flags. No backpressure.
module status_register_stack #(
    parameter int SREG_W      = 32,
    parameter int FLAG_LSB    = 28,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              negative_in,
    input  logic              zero_in,
    input  logic              carry_in,
    input  logic              overflow_in,
    input  logic              update_sreg,
    input  logic [3:0]        flag_mask,
    input  logic              push,
    input  logic              pop,
    input  logic [3:0]        cond,
    output logic              cond_true,
    output logic [SREG_W-1:0] sreg,
    output logic              negative_out,
    output logic              zero_out,
    output logic              carry_out,
    output logic              overflow_out,
    output logic [CNT_W-1:0]  depth,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [3:0]       r_flags;
    logic [3:0]       r_stack [STACK_DEPTH];
    logic [CNT_W-1:0] r_depth;
    logic             r_err;

    logic [3:0]       w_mask;
    logic [3:0]       w_upd_flags;
    logic [3:0]       w_top;
    logic [3:0]       w_next_flags;
    logic             w_full;
    logic             w_empty;
    logic             w_both;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_err_set;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;

    assign w_mask      = flag_mask & {4{update_sreg}};
    assign w_upd_flags = (r_flags & ~w_mask)
                       | ({negative_in, zero_in, carry_in, overflow_in} & w_mask);
    assign w_full      = (r_depth == FULL_CNT);
    assign w_empty     = (r_depth == '0);
    assign w_both      = push & pop;
    assign w_do_push   = push & ~pop & ~w_full;
    assign w_do_pop    = pop & ~push & ~w_empty;
    assign w_err_set   = w_both | (push & w_full) | (pop & w_empty);

    // Entry depth-1 is the top of stack; selected by compare to keep index widths exact.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_depth == CNT_W'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    // A successful pop wins over the ALU; a push/pop collision freezes the flags.
    always_comb begin
        w_next_flags = r_flags;
        if (w_do_pop) begin
            w_next_flags = w_top;
        end else if (!w_both) begin
            w_next_flags = w_upd_flags;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_flags <= w_next_flags;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_do_push) begin
                r_depth <= r_depth + ONE_CNT;
            end else if (w_do_pop) begin
                r_depth <= r_depth - ONE_CNT;
            end
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (w_do_push && (r_depth == CNT_W'(i))) begin
                    r_stack[i] <= r_flags;
                end
            end
        end
    end

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            4'h0: cond_true = w_z;
            4'h1: cond_true = ~w_z;
            4'h2: cond_true = w_c;
            4'h3: cond_true = ~w_c;
            4'h4: cond_true = w_n;
            4'h5: cond_true = ~w_n;
            4'h6: cond_true = w_v;
            4'h7: cond_true = ~w_v;
            4'h8: cond_true = w_c & ~w_z;
            4'h9: cond_true = ~(w_c & ~w_z);
            4'hA: cond_true = (w_n == w_v);
            4'hB: cond_true = (w_n != w_v);
            4'hC: cond_true = ~w_z & (w_n == w_v);
            4'hD: cond_true = ~(~w_z & (w_n == w_v));
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        sreg = '0;
        sreg[FLAG_LSB +: 4] = r_flags;
    end

    assign negative_out = r_flags[3];
    assign zero_out     = r_flags[2];
    assign carry_out    = r_flags[1];
    assign overflow_out = r_flags[0];
    assign depth        = r_depth;
    assign stack_full   = w_full;
    assign stack_empty  = w_empty;
    assign stack_err    = r_err;
endmodule
